mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter DW, 16, memory data width.
REQ-002 Parameter AW, 5, memory address width (depth 2^AW = 32 words).
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 mode  in  1  0 = copy, 1 = fill; captured at start.
REQ-007 src  in  AW  copy source base address; captured at start.
REQ-008 dst  in  AW  destination base address; captured at start.
REQ-009 len  in  AW+1  word count; captured at start.
REQ-010 fill_val  in  DW  fill data; captured at start.
REQ-011 abort  in  1  early-termination request.
REQ-012 busy  out  1  high in RD and WR states.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 aborted  out  1  valid with done; 1 if job ended by abort.
REQ-015 words_done  out  AW+1  words written in current or last job.
REQ-016 m_rd  out  1  memory read strobe.
REQ-017 m_raddr  out  AW  memory read address.
REQ-018 m_wr  out  1  memory write strobe.
REQ-019 m_waddr  out  AW  memory write address.
REQ-020 m_din  out  DW  memory write data.
REQ-021 m_dout  in  DW  memory read data; valid the cycle after m_rd is sampled.

Function
REQ-022 FSM states SHALL be IDLE, RD, WR, DONE.
REQ-023 IDLE: start=1 SHALL capture mode/src/dst/len/fill_val, clear words_done and the aborted flag, and move to DONE if the effective len = 0, else to RD (copy) or WR (fill).
REQ-024 Effective len SHALL be min(len, 32); len > 32 SHALL be treated as 32.
REQ-025 RD: m_rd=1, m_raddr=src+i (mod 32), m_wr=0; next state WR.
REQ-026 WR: m_wr=1, m_waddr=dst+i (mod 32), m_rd=0; m_din = m_dout (copy) or fill_val (fill).
REQ-027 On each WR cycle, i and words_done SHALL increment by 1.
REQ-028 After WR, next state SHALL be DONE if i+1 = effective len, else RD (copy) or WR (fill).
REQ-029 m_rd and m_wr SHALL never both be 1 in the same cycle.
REQ-030 m_rd, m_wr, m_raddr, m_waddr SHALL decode from registered state only; no combinational path from start or abort.
REQ-031 Address arithmetic SHALL be AW-bit wrap-around; 31+1 = 0.
REQ-032 DONE: done=1 for exactly one cycle; aborted valid the same cycle; next state IDLE.
REQ-033 Copy job of N words SHALL hold busy for exactly 2N cycles; fill job for exactly N cycles; done follows the last busy cycle.
REQ-034 abort=1 in RD SHALL skip the pending write and go to DONE with aborted=1.
REQ-035 abort=1 in WR SHALL complete that write, count it, then go to DONE with aborted=1.
REQ-036 abort in IDLE or DONE SHALL be ignored.
REQ-037 start while busy or in DONE SHALL be ignored; start and abort together in IDLE SHALL start the job.
REQ-038 Overlapping src/dst ranges SHALL be copied in ascending order, with no overlap correction.
REQ-039 words_done SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-040 rst=0 at a posedge SHALL force IDLE and set busy=0, done=0, aborted=0, words_done=0, m_rd=0, m_wr=0, m_raddr=0, m_waddr=0, m_din=0.
REQ-041 Reset asserted mid-job SHALL terminate the job within the same edge, with no further m_rd/m_wr and no done pulse.
REQ-042 After reset deassertion, the first start SHALL be accepted on the next posedge.

Verification
REQ-043 Copy mode, src=2, dst=10, len=3, memory[2..4]=A1,B2,C3 -> busy for 6 cycles; memory[10..12]=A1,B2,C3; done one cycle; words_done=3; aborted=0.
REQ-044 Fill mode, dst=30, len=4, fill_val=5555 -> writes to 30,31,0,1 on 4 consecutive cycles; done; words_done=4.
REQ-045 len=0 then len=40 -> first: done the cycle after start, no m_rd/m_wr; second: 32 words moved, words_done=32.
REQ-046 Copy len=5 with abort asserted in the 3rd RD cycle -> words_done=2, no 3rd write, done with aborted=1; abort in a WR cycle -> that write lands and is counted.
REQ-047 rst=0 during copy WR of word 1 of 4 -> next cycle busy=0, m_wr=0, words_done=0, no done pulse; a new start is accepted normally.
REQ-048 Every scenario: assert m_rd&m_wr never high together; start pulses while busy have no effect.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Bundle of job-control and memory-port signals for mem_copy_engine.
// The engine connects through the slave modport; the job issuer and memory through master.
interface mem_copy_engine_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 5
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill_val;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW:0]   words_done;
  logic          m_rd;
  logic [AW-1:0] m_raddr;
  logic          m_wr;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  modport master (
    output start, mode, src, dst, len, fill_val, abort, m_dout,
    input  busy, done, aborted, words_done, m_rd, m_raddr, m_wr, m_waddr, m_din
  );

  modport slave (
    input  start, mode, src, dst, len, fill_val, abort, m_dout,
    output busy, done, aborted, words_done, m_rd, m_raddr, m_wr, m_waddr, m_din
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-at-a-time memory copy/fill engine over a single-port-style read/write strobe interface.
// Copy alternates RD/WR per word; fill issues back-to-back WR cycles.
module mem_copy_engine #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 5
) (
  input logic              clk,
  input logic              rst,
  mem_copy_engine_if.slave bus
);

  localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] fill_q, fill_d;
  logic          aborted_q, aborted_d;

  logic [AW:0]   eff_len;
  logic          last_word;

  // Requests longer than the memory are clamped to one full pass.
  assign eff_len   = (bus.len > MaxLen) ? MaxLen : bus.len;
  assign last_word = ((cnt_q + CntOne) == len_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          src_d     = bus.src;
          dst_d     = bus.dst;
          len_d     = eff_len;
          fill_d    = bus.fill_val;
          cnt_d     = '0;
          aborted_d = 1'b0;
          if (eff_len == '0) begin
            state_d = StDone;
          end else begin
            state_d = bus.mode ? StWr : StRd;
          end
        end
      end
      StRd: begin
        // Abort during a read drops the word before its write is issued.
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        cnt_d = cnt_q + CntOne;
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (last_word) begin
          state_d = StDone;
        end else begin
          state_d = mode_q ? StWr : StRd;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  // Strobes and addresses come only from registered state; write data may pass m_dout through.
  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.aborted    = 1'b0;
    bus.words_done = cnt_q;
    bus.m_rd       = 1'b0;
    bus.m_raddr    = '0;
    bus.m_wr       = 1'b0;
    bus.m_waddr    = '0;
    bus.m_din      = '0;
    unique case (state_q)
      StRd: begin
        bus.busy    = 1'b1;
        bus.m_rd    = 1'b1;
        bus.m_raddr = src_q + cnt_q[AW-1:0];
      end
      StWr: begin
        bus.busy    = 1'b1;
        bus.m_wr    = 1'b1;
        bus.m_waddr = dst_q + cnt_q[AW-1:0];
        bus.m_din   = mode_q ? fill_q : bus.m_dout;
      end
      StDone: begin
        bus.done    = 1'b1;
        bus.aborted = aborted_q;
      end
      default: begin
      end
    endcase
  end

endmodule
